// File: rtl/sram_bus_ctrl.sv
// Bus-side initiator for a single-port SRAM: arbitrates read/write request channels
// onto one SRAM port and returns responses, one transaction outstanding at a time.
module sram_bus_ctrl #(
   parameter int unsigned addr_width = 8,
   parameter logic [31:0] base_addr  = 32'h0000_0000
) (
   input  logic                  clock,
   input  logic                  reset,

   input  logic                  rreq_valid,
   output logic                  rreq_ready,
   input  logic [31:0]           rreq_addr,
   output logic                  rresp_valid,
   input  logic                  rresp_ready,
   output logic [31:0]           rresp_data,
   output logic                  rresp_err,

   input  logic                  wreq_valid,
   output logic                  wreq_ready,
   input  logic [31:0]           wreq_addr,
   input  logic [31:0]           wreq_data,
   input  logic [3:0]            wreq_strobe,
   output logic                  wresp_valid,
   input  logic                  wresp_ready,
   output logic                  wresp_err,

   output logic                  sram_en,
   output logic                  sram_wen,
   output logic [3:0]            sram_wmask,
   output logic [addr_width-1:0] sram_addr,
   output logic [31:0]           sram_din,
   input  logic [31:0]           sram_dout
);

   // Handshake rule on every channel: a beat transfers on the rising clock edge
   // where valid && ready; a valid beat holds its payload stable until then.

   localparam int unsigned TagLsb = addr_width + 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_RESP = 2'd1,
      WR_RESP = 2'd2
   } state_e;

   typedef enum logic {
      GRANT_READ  = 1'b0,
      GRANT_WRITE = 1'b1
   } grant_e;

   state_e state_q;
   grant_e last_grant_q;
   logic   rresp_valid_q;
   logic   wresp_valid_q;
   logic   rresp_err_q;
   logic   wresp_err_q;

   logic   rd_grant;
   logic   wr_grant;
   logic   rd_acc;
   logic   wr_acc;
   logic   rd_in_win;
   logic   wr_in_win;
   logic   can_accept;

   assign rd_in_win = (rreq_addr[31:TagLsb] == base_addr[31:TagLsb]);
   assign wr_in_win = (wreq_addr[31:TagLsb] == base_addr[31:TagLsb]);

   // On contention the channel not served last time wins.
   assign rd_grant = rreq_valid && (!wreq_valid || (last_grant_q == GRANT_WRITE));
   assign wr_grant = wreq_valid && (!rreq_valid || (last_grant_q == GRANT_READ));

   // Reset gates the readies so nothing can be accepted (or reach the SRAM) while it is low.
   assign can_accept = reset && (state_q == IDLE);
   assign rreq_ready = can_accept && rd_grant;
   assign wreq_ready = can_accept && wr_grant;
   assign rd_acc     = rreq_valid && rreq_ready;
   assign wr_acc     = wreq_valid && wreq_ready;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         last_grant_q  <= GRANT_WRITE;
         rresp_valid_q <= 1'b0;
         wresp_valid_q <= 1'b0;
         rresp_err_q   <= 1'b0;
         wresp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (rd_acc) begin
                  state_q       <= RD_RESP;
                  last_grant_q  <= GRANT_READ;
                  rresp_valid_q <= 1'b1;
                  rresp_err_q   <= !rd_in_win;
               end else if (wr_acc) begin
                  state_q       <= WR_RESP;
                  last_grant_q  <= GRANT_WRITE;
                  wresp_valid_q <= 1'b1;
                  wresp_err_q   <= !wr_in_win;
               end
            end
            RD_RESP: begin
               if (rresp_ready) begin
                  state_q       <= IDLE;
                  rresp_valid_q <= 1'b0;
                  rresp_err_q   <= 1'b0;
               end
            end
            WR_RESP: begin
               if (wresp_ready) begin
                  state_q       <= IDLE;
                  wresp_valid_q <= 1'b0;
                  wresp_err_q   <= 1'b0;
               end
            end
            default: begin
               state_q       <= IDLE;
               rresp_valid_q <= 1'b0;
               wresp_valid_q <= 1'b0;
               rresp_err_q   <= 1'b0;
               wresp_err_q   <= 1'b0;
            end
         endcase
      end
   end

   assign rresp_valid = rresp_valid_q;
   assign rresp_err   = rresp_err_q;
   assign wresp_valid = wresp_valid_q;
   assign wresp_err   = wresp_err_q;

   // sram_dout stays put during RD_RESP since no further read is issued until the handshake.
   assign rresp_data = (rresp_valid_q && !rresp_err_q) ? sram_dout : 32'h0;

   always_comb begin
      sram_en    = 1'b0;
      sram_wen   = 1'b0;
      sram_wmask = 4'h0;
      sram_addr  = '0;
      sram_din   = 32'h0;
      if (rd_acc && rd_in_win) begin
         sram_en   = 1'b1;
         sram_addr = rreq_addr[TagLsb-1:2];
      end else if (wr_acc && wr_in_win) begin
         sram_en    = 1'b1;
         sram_wen   = 1'b1;
         sram_wmask = wreq_strobe;
         sram_addr  = wreq_addr[TagLsb-1:2];
         sram_din   = wreq_data;
      end
   end

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Self-checking bench for sram_bus_ctrl: behavioural SRAM, reference memory,
// scoreboard of expected responses, directed scenarios plus a random phase.
module tb_sram_bus_ctrl;

   localparam int unsigned AW   = 8;
   localparam logic [31:0] BASE = 32'h8000_0C00;
   localparam int unsigned WORDS = 1 << AW;

   logic          clock;
   logic          reset;
   logic          rreq_valid;
   logic          rreq_ready;
   logic [31:0]   rreq_addr;
   logic          rresp_valid;
   logic          rresp_ready;
   logic [31:0]   rresp_data;
   logic          rresp_err;
   logic          wreq_valid;
   logic          wreq_ready;
   logic [31:0]   wreq_addr;
   logic [31:0]   wreq_data;
   logic [3:0]    wreq_strobe;
   logic          wresp_valid;
   logic          wresp_ready;
   logic          wresp_err;
   logic          sram_en;
   logic          sram_wen;
   logic [3:0]    sram_wmask;
   logic [AW-1:0] sram_addr;
   logic [31:0]   sram_din;
   logic [31:0]   sram_dout;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // {is_write, err, data}
   logic [33:0] exp_q[$];
   logic [33:0] e;
   logic [31:0] ref_mem [0:WORDS-1];
   logic        ref_init = 1'b0;
   logic        rd_acc_prev = 1'b0;
   logic [31:0] last_rdata = 32'h0;

   logic [31:0] mem [0:WORDS-1];
   logic        mem_init = 1'b0;

   sram_bus_ctrl #(.addr_width(AW), .base_addr(BASE)) dut (
      .clock       (clock),
      .reset       (reset),
      .rreq_valid  (rreq_valid),
      .rreq_ready  (rreq_ready),
      .rreq_addr   (rreq_addr),
      .rresp_valid (rresp_valid),
      .rresp_ready (rresp_ready),
      .rresp_data  (rresp_data),
      .rresp_err   (rresp_err),
      .wreq_valid  (wreq_valid),
      .wreq_ready  (wreq_ready),
      .wreq_addr   (wreq_addr),
      .wreq_data   (wreq_data),
      .wreq_strobe (wreq_strobe),
      .wresp_valid (wresp_valid),
      .wresp_ready (wresp_ready),
      .wresp_err   (wresp_err),
      .sram_en     (sram_en),
      .sram_wen    (sram_wen),
      .sram_wmask  (sram_wmask),
      .sram_addr   (sram_addr),
      .sram_din    (sram_din),
      .sram_dout   (sram_dout)
   );

   // ---------------- clock / reset ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #300000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- behavioural SRAM (1-cycle read, output held) ----------------
   always @(posedge clock) begin
      if (!mem_init) begin
         for (int i = 0; i < WORDS; i++) mem[i] <= 32'h0;
         sram_dout <= 32'h0;
         mem_init  <= 1'b1;
      end else if (sram_en) begin
         if (sram_wen) begin
            for (int b = 0; b < 4; b++)
               if (sram_wmask[b]) mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
         end else begin
            sram_dout <= mem[sram_addr];
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic in_win(input logic [31:0] a);
      return a[31:AW+2] == BASE[31:AW+2];
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   // ---------------- monitor + scoreboard ----------------
   always @(negedge clock) begin
      logic rd_acc, wr_acc;
      logic [AW-1:0] idx;
      if (!ref_init) begin
         for (int i = 0; i < WORDS; i++) ref_mem[i] = 32'h0;
         ref_init = 1'b1;
      end
      if (!reset) begin
         exp_q.delete();
         rd_acc_prev = 1'b0;
         check("rst_rresp_valid", 64'(rresp_valid), 64'd0);
         check("rst_wresp_valid", 64'(wresp_valid), 64'd0);
         check("rst_rreq_ready", 64'(rreq_ready), 64'd0);
         check("rst_wreq_ready", 64'(wreq_ready), 64'd0);
         check("rst_sram_en", 64'(sram_en), 64'd0);
      end else begin
         rd_acc = rreq_valid && rreq_ready;
         wr_acc = wreq_valid && wreq_ready;
         if (rd_acc_prev) check("rd_latency_valid", 64'(rresp_valid), 64'd1);
         if (!rresp_valid) check("rresp_err_idle", 64'(rresp_err), 64'd0);
         if (!wresp_valid) check("wresp_err_idle", 64'(wresp_err), 64'd0);

         if (rresp_valid && rresp_ready) begin
            if (exp_q.size() == 0) check("rresp_unexpected", 64'(rresp_valid), 64'd0);
            else begin
               e = exp_q.pop_front();
               check("rresp_kind", 64'(e[33]), 64'd0);
               check("rresp_err", 64'(rresp_err), 64'(e[32]));
               check("rresp_data", 64'(rresp_data), 64'(e[31:0]));
               last_rdata = rresp_data;
            end
         end
         if (wresp_valid && wresp_ready) begin
            if (exp_q.size() == 0) check("wresp_unexpected", 64'(wresp_valid), 64'd0);
            else begin
               e = exp_q.pop_front();
               check("wresp_kind", 64'(e[33]), 64'd1);
               check("wresp_err", 64'(wresp_err), 64'(e[32]));
            end
         end

         check("one_accept", 64'(rd_acc && wr_acc), 64'd0);
         if (rd_acc) begin
            idx = rreq_addr[AW+1:2];
            if (in_win(rreq_addr)) begin
               check("rd_sram_en", 64'(sram_en), 64'd1);
               check("rd_sram_wen", 64'(sram_wen), 64'd0);
               check("rd_sram_addr", 64'(sram_addr), 64'(idx));
               exp_q.push_back({1'b0, 1'b0, ref_mem[idx]});
            end else begin
               check("rd_oow_sram_en", 64'(sram_en), 64'd0);
               exp_q.push_back({1'b0, 1'b1, 32'h0});
            end
         end else if (wr_acc) begin
            idx = wreq_addr[AW+1:2];
            if (in_win(wreq_addr)) begin
               check("wr_sram_en", 64'(sram_en), 64'd1);
               check("wr_sram_wen", 64'(sram_wen), 64'd1);
               check("wr_sram_addr", 64'(sram_addr), 64'(idx));
               check("wr_sram_wmask", 64'(sram_wmask), 64'(wreq_strobe));
               check("wr_sram_din", 64'(sram_din), 64'(wreq_data));
               ref_mem[idx] = merge(ref_mem[idx], wreq_data, wreq_strobe);
               exp_q.push_back({1'b1, 1'b0, 32'h0});
            end else begin
               check("wr_oow_sram_en", 64'(sram_en), 64'd0);
               exp_q.push_back({1'b1, 1'b1, 32'h0});
            end
         end else begin
            check("idle_sram_en", 64'(sram_en), 64'd0);
            check("idle_sram_wmask", 64'(sram_wmask), 64'd0);
         end
         rd_acc_prev = rd_acc;
      end
   end

   // ---------------- driver tasks (called at posedge+1) ----------------
   task automatic do_read(input logic [31:0] a);
      logic ok;
      ok = 1'b0;
      rreq_valid = 1'b1;
      rreq_addr  = a;
      for (int c = 0; c < 50 && !ok; c++) begin
         @(negedge clock);
         if (rreq_ready) ok = 1'b1;
      end
      check("rd_accept_timeout", 64'(ok), 64'd1);
      @(posedge clock); #1;
      rreq_valid = 1'b0;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic ok;
      ok = 1'b0;
      wreq_valid  = 1'b1;
      wreq_addr   = a;
      wreq_data   = d;
      wreq_strobe = s;
      for (int c = 0; c < 50 && !ok; c++) begin
         @(negedge clock);
         if (wreq_ready) ok = 1'b1;
      end
      check("wr_accept_timeout", 64'(ok), 64'd1);
      @(posedge clock); #1;
      wreq_valid = 1'b0;
   endtask

   task automatic wait_drain();
      for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(posedge clock);
      check("drain_timeout", 64'(exp_q.size()), 64'd0);
      @(posedge clock); #1;
   endtask

   // ---------------- stimulus ----------------
   int          n;
   logic        grant_w [0:3];
   int          acc_cyc [0:3];
   logic        ok;

   initial begin
      reset       = 1'b0;
      rreq_valid  = 1'b0;
      rreq_addr   = 32'h0;
      rresp_ready = 1'b1;
      wreq_valid  = 1'b0;
      wreq_addr   = 32'h0;
      wreq_data   = 32'h0;
      wreq_strobe = 4'h0;
      wresp_ready = 1'b1;
      repeat (3) @(posedge clock);
      #1 reset = 1'b1;
      @(negedge clock);
      check("init_rresp_valid", 64'(rresp_valid), 64'd0);
      check("init_wresp_valid", 64'(wresp_valid), 64'd0);
      check("init_rreq_ready", 64'(rreq_ready), 64'd0);
      @(posedge clock); #1;

      // basic write then read
      do_write(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF);
      do_read(BASE + 32'h10);
      wait_drain();
      check("basic_readback", 64'(last_rdata), 64'hDEAD_BEEF);

      // byte mask, plus an all-zero strobe that must not modify anything
      do_write(BASE + 32'h20, 32'h1122_3344, 4'hF);
      do_write(BASE + 32'h20, 32'hAABB_CCDD, 4'b0101);
      do_read(BASE + 32'h20);
      wait_drain();
      check("mask_readback", 64'(last_rdata), 64'h11BB_33DD);
      do_write(BASE + 32'h20, 32'hFFFF_FFFF, 4'b0000);
      do_read(BASE + 32'h20);
      wait_drain();
      check("zero_strobe_readback", 64'(last_rdata), 64'h11BB_33DD);

      // arbitration: last grant is a write, so the contested sequence starts with a read
      do_write(BASE + 32'h30, 32'h0000_0030, 4'hF);
      n = 0;
      rreq_valid  = 1'b1;
      rreq_addr   = BASE + 32'h10;
      wreq_valid  = 1'b1;
      wreq_addr   = BASE + 32'h30;
      wreq_data   = 32'h3030_3030;
      wreq_strobe = 4'hF;
      for (int c = 0; c < 40 && n < 4; c++) begin
         @(negedge clock);
         if (rreq_ready || wreq_ready) begin
            grant_w[n] = wreq_ready;
            acc_cyc[n] = cyc;
            n++;
         end
      end
      @(posedge clock); #1;
      rreq_valid = 1'b0;
      wreq_valid = 1'b0;
      check("arb_count", 64'(n), 64'd4);
      for (int i = 0; i < n; i++) check("arb_order", 64'(grant_w[i]), 64'(i % 2));
      for (int i = 1; i < n; i++) check("arb_spacing", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd2);
      wait_drain();

      // read backpressure with a competing write
      rresp_ready = 1'b0;
      do_read(BASE + 32'h10);
      wreq_valid  = 1'b1;
      wreq_addr   = BASE + 32'h40;
      wreq_data   = 32'h4444_4444;
      wreq_strobe = 4'hF;
      for (int c = 0; c < 5; c++) begin
         @(negedge clock);
         check("bp_rresp_valid", 64'(rresp_valid), 64'd1);
         check("bp_rresp_data", 64'(rresp_data), 64'hDEAD_BEEF);
         check("bp_wreq_ready", 64'(wreq_ready), 64'd0);
         check("bp_sram_en", 64'(sram_en), 64'd0);
      end
      @(posedge clock); #1;
      rresp_ready = 1'b1;
      @(negedge clock);
      check("bp_handshake_valid", 64'(rresp_valid), 64'd1);
      @(posedge clock); #1;
      @(negedge clock);
      check("bp_write_accept_next_idle", 64'(wreq_ready), 64'd1);
      @(posedge clock); #1;
      wreq_valid = 1'b0;
      wait_drain();

      // out-of-window accesses alias word 0 but must never touch it
      do_write(BASE + (32'd4 << AW), 32'hCAFE_F00D, 4'hF);
      do_read(BASE + (32'd4 << AW));
      do_read(BASE);
      wait_drain();
      check("oow_mem_unchanged", 64'(last_rdata), 64'h0);

      // random mixed traffic
      for (int t = 0; t < 30; t++) begin
         logic [31:0] a;
         a = BASE + (32'($urandom_range(0, WORDS - 1)) << 2) + 32'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) a = a ^ 32'h0100_0000;
         if ($urandom_range(0, 1) == 1) do_write(a, $urandom, 4'($urandom_range(0, 15)));
         else do_read(a);
      end
      wait_drain();

      // asynchronous reset while a read response is pending
      rresp_ready = 1'b0;
      do_read(BASE + 32'h10);
      @(negedge clock);
      check("pre_rst_rresp_valid", 64'(rresp_valid), 64'd1);
      #2 reset = 1'b0;
      #1;
      check("async_rst_rresp_valid", 64'(rresp_valid), 64'd0);
      rreq_valid  = 1'b1;
      rreq_addr   = BASE + 32'h10;
      wreq_valid  = 1'b1;
      wreq_addr   = BASE + 32'h50;
      wreq_data   = 32'h5555_5555;
      wreq_strobe = 4'hF;
      repeat (2) @(posedge clock);
      #1;
      reset       = 1'b1;
      rresp_ready = 1'b1;
      @(negedge clock);
      check("post_rst_rreq_ready", 64'(rreq_ready), 64'd1);
      check("post_rst_wreq_ready", 64'(wreq_ready), 64'd0);
      @(posedge clock); #1;
      rreq_valid = 1'b0;
      ok = 1'b0;
      for (int c = 0; c < 20 && !ok; c++) begin
         @(negedge clock);
         if (wreq_ready) ok = 1'b1;
      end
      check("post_rst_write_accept", 64'(ok), 64'd1);
      @(posedge clock); #1;
      wreq_valid = 1'b0;
      wait_drain();
      do_read(BASE + 32'h50);
      wait_drain();
      check("post_rst_readback", 64'(last_rdata), 64'h5555_5555);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sram_bus_ctrl.md
Name: sram_bus_ctrl

Overview:
- Bus-side initiator for the single-port sram_1r1w data/instruction memory.
- Accepts valid/ready read and write request channels from the core, arbitrates them onto the single SRAM port, and returns read data and write responses on valid/ready response channels.
- Exactly one transaction is outstanding at a time.
- Out-of-window addresses are answered with an error and never reach the SRAM.

Parameters:
- addr_width, 8, SRAM word-address width; SRAM holds 1<<addr_width 32-bit words.
- base_addr, 32'h0000_0000, byte base address of the SRAM window; must be aligned to the window size (4<<addr_width).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- rreq_valid  in  1  read request valid
- rreq_ready  out  1  read request accepted
- rreq_addr  in  32  read byte address
- rresp_valid  out  1  read response valid
- rresp_ready  in  1  read response taken
- rresp_data  out  32  read data
- rresp_err  out  1  read address out of window
- wreq_valid  in  1  write request valid
- wreq_ready  out  1  write request accepted
- wreq_addr  in  32  write byte address
- wreq_data  in  32  write data
- wreq_strobe  in  4  byte enables, bit i = byte lane i
- wresp_valid  out  1  write response valid
- wresp_ready  in  1  write response taken
- wresp_err  out  1  write address out of window
- sram_en  out  1  SRAM enable
- sram_wen  out  1  SRAM write enable
- sram_wmask  out  4  SRAM byte mask
- sram_addr  out  addr_width  SRAM word address
- sram_din  out  32  SRAM write data
- sram_dout  in  32  SRAM read data; valid the cycle after a read issue, held until the next read

Behaviour:
- FSM states: IDLE, RD_RESP, WR_RESP.
- State, rresp_err_q, wresp_err_q and last_grant are flops.
  - Reset values: IDLE, 0, 0, last_grant=WRITE, so the first contested grant goes to the read.
- Reset is asynchronous and can assert mid-transaction.
  - It forces IDLE and drops rresp_valid/wresp_valid.
  - The pending response is discarded.
  - No SRAM access is issued while reset is low.
- Arbitration (combinational, IDLE only):
  - If only one request is valid, it is granted.
  - If both are valid, grant the channel opposite to last_grant.
  - last_grant updates on every accepted request.
- rreq_ready = IDLE && read granted; wreq_ready = IDLE && write granted; both are 0 outside IDLE.
- In-window test: addr[31:addr_width+2] == base_addr[31:addr_width+2]. Byte address bits [1:0] are ignored.
- SRAM drive is combinational from the accept handshake, so the access happens at the accepting edge.
  - Accepted in-window read: sram_en=1, sram_wen=0, sram_addr=addr[addr_width+1:2].
  - Accepted in-window write: sram_en=1, sram_wen=1, sram_wmask=wreq_strobe, sram_addr=word address, sram_din=wreq_data. A strobe of 4'b0000 is still issued and modifies no bytes.
  - Error requests and idle cycles drive sram_en=0, sram_wen=0, sram_wmask=0, sram_addr=0, sram_din=0.
- Read accept at edge T:
  - Next state RD_RESP; rresp_valid=1 from the cycle after T.
  - rresp_data = sram_dout, or 0 if rresp_err.
  - sram_dout stays stable because no SRAM read is issued until the response completes.
  - Read latency is 1 cycle.
- Write accept at edge T: next state WR_RESP; wresp_valid=1 from the cycle after T.
- RD_RESP/WR_RESP hold valid, data and err stable until the response ready is high. Return to IDLE on that edge.
  - A new request can be accepted in the IDLE cycle that follows, so peak throughput is one transaction per 2 cycles.
- Responses are in request order by construction.
- Response valids are 0 in IDLE; err outputs are 0 whenever the corresponding valid is 0.

Test Plan:
- Write 0xDEADBEEF to base+0x10 with strobe 4'hF, then read base+0x10 → sram_en/wen/addr=0x04 at the accepting edge; wresp_err=0; read returns 0xDEADBEEF, rresp_err=0, rresp_valid exactly 1 cycle after accept.
- Byte mask: preload word 0x11223344 at base+0x20, write 0xAABBCCDD with strobe 4'b0101, read back → 0x11BB33DD.
- Arbitration: hold rreq_valid and wreq_valid together for 4 transactions with rresp_ready=wresp_ready=1 → grant order read, write, read, write; accepts spaced 2 cycles apart.
- Backpressure: read base+0x10 with rresp_ready=0 for 5 cycles, write requests valid meanwhile → rresp_valid/rresp_data=0xDEADBEEF stable for 5 cycles, wreq_ready=0, sram_en=0; write accepted in the IDLE cycle after the response handshake.
- Out-of-window: read and write at base+(4<<addr_width) → sram_en never asserted; rresp_err=1 with rresp_data=0; wresp_err=1; memory unchanged on readback.
- Reset mid-transaction: drop reset in RD_RESP with rresp_ready=0 → rresp_valid=0 immediately (asynchronous); after release both readies follow the arbitration rule and a contested first grant goes to the read.
